// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave arbiter that serialises captured requests and routes responses back.
// Optional ARB_TIMEOUT_EN aborts a WAIT after TIMEOUT_CYCLES with 32'hDEADBEEF and a sticky o_timeout.
module bus_arbiter #(
    parameter bit RR_EN          = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_m0_data,
    input  logic [31:0] i_m0_address,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write_notread,
    input  logic        i_m0_DV,
    input  logic [31:0] i_m1_data,
    input  logic [31:0] i_m1_address,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write_notread,
    input  logic        i_m1_DV,
    output logic [31:0] o_m0_data,
    output logic        o_m0_DV,
    output logic [31:0] o_m1_data,
    output logic        o_m1_DV,
    output logic [31:0] o_slv_data,
    output logic [31:0] o_slv_address,
    output logic [2:0]  o_slv_bhw,
    output logic        o_slv_write_notread,
    output logic        o_slv_DV,
    input  logic [31:0] i_slv_data,
    input  logic        i_slv_DV,
    output logic        o_grant,
    output logic        o_busy,
    output logic        o_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t           state_q, state_d;
    logic [1:0]       pend_q, pend_d, in_dv, in_wn, take, clr;
    logic [1:0][31:0] in_addr, in_data, req_addr_q, req_data_q;
    logic [1:0][2:0]  in_bhw, req_bhw_q;
    logic [1:0]       req_wn_q;
    logic             grant_q, grant_d, last_q, last_d, sel, fin;
    logic [31:0]      fin_data;
    logic [31:0]      slv_addr_q, slv_addr_d, slv_data_q, slv_data_d;
    logic [2:0]       slv_bhw_q, slv_bhw_d;
    logic             slv_wn_q, slv_wn_d, slv_dv_q, slv_dv_d;
    logic [1:0]       m_dv_q, m_dv_d;
    logic [1:0][31:0] m_data_q, m_data_d;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif
    assign in_dv   = {i_m1_DV, i_m0_DV};
    assign in_wn   = {i_m1_write_notread, i_m0_write_notread};
    assign in_addr = {i_m1_address, i_m0_address};
    assign in_data = {i_m1_data, i_m0_data};
    assign in_bhw  = {i_m1_bhw, i_m0_bhw};
    // A pending master's register is frozen, so a repeated pulse cannot corrupt it.
    assign take    = in_dv & ~pend_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        slv_addr_d = slv_addr_q;
        slv_data_d = slv_data_q;
        slv_bhw_d  = slv_bhw_q;
        slv_wn_d   = slv_wn_q;
        slv_dv_d   = 1'b0;
        m_dv_d     = 2'b00;
        m_data_d   = m_data_q;
        clr        = 2'b00;
        sel        = (pend_q == 2'b11) ? (RR_EN ? ~last_q : 1'b0) : pend_q[1];
        fin        = (state_q == WAIT) && i_slv_DV;
        fin_data   = i_slv_data;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
        tmo_d      = tmo_q;
        if (state_q == WAIT && !i_slv_DV && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            fin      = 1'b1;
            fin_data = 32'hDEADBEEF;
            tmo_d    = 1'b1;
        end
`endif
        case (state_q)
            IDLE: if (|pend_q) begin
                grant_d    = sel;
                slv_addr_d = req_addr_q[sel];
                slv_data_d = req_data_q[sel];
                slv_bhw_d  = req_bhw_q[sel];
                slv_wn_d   = req_wn_q[sel];
                state_d    = ISSUE;
            end
            // The slave strobe is registered, so it is seen in the first WAIT cycle.
            ISSUE: begin
                slv_dv_d = 1'b1;
                state_d  = WAIT;
            end
            WAIT: if (fin) begin
                m_dv_d[grant_q]   = 1'b1;
                m_data_d[grant_q] = fin_data;
                clr[grant_q]      = 1'b1;
                last_d            = grant_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q & ~clr) | take;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_bhw_q  <= '0;
            req_wn_q   <= '0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            slv_addr_q <= '0;
            slv_data_q <= '0;
            slv_bhw_q  <= '0;
            slv_wn_q   <= 1'b0;
            slv_dv_q   <= 1'b0;
            m_dv_q     <= '0;
            m_data_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            slv_addr_q <= slv_addr_d;
            slv_data_q <= slv_data_d;
            slv_bhw_q  <= slv_bhw_d;
            slv_wn_q   <= slv_wn_d;
            slv_dv_q   <= slv_dv_d;
            m_dv_q     <= m_dv_d;
            m_data_q   <= m_data_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
`endif
            for (int n = 0; n < 2; n++)
                if (take[n]) begin
                    req_addr_q[n] <= in_addr[n];
                    req_data_q[n] <= in_data[n];
                    req_bhw_q[n]  <= in_bhw[n];
                    req_wn_q[n]   <= in_wn[n];
                end
        end
    end

    assign o_m0_data           = m_data_q[0];
    assign o_m1_data           = m_data_q[1];
    assign o_m0_DV             = m_dv_q[0];
    assign o_m1_DV             = m_dv_q[1];
    assign o_slv_data          = slv_data_q;
    assign o_slv_address       = slv_addr_q;
    assign o_slv_bhw           = slv_bhw_q;
    assign o_slv_write_notread = slv_wn_q;
    assign o_slv_DV            = slv_dv_q;
    assign o_grant             = grant_q;
    assign o_busy              = state_q != IDLE;
`ifdef ARB_TIMEOUT_EN
    assign o_timeout           = tmo_q;
`else
    logic unused_timeout;
    assign unused_timeout      = ^TIMEOUT_CYCLES;
    assign o_timeout           = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for a round-robin arbiter (d=0) and a fixed-priority arbiter (d=1).
// Each DUT has its own slave model answering 3 cycles after o_slv_DV.
module tb_bus_arbiter;
    localparam int TO = 8;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  bhw;
        logic        wn;
        logic        m;
    } iss_t;
    typedef struct packed {
        logic        care;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m_data[2][2], m_addr[2][2], md_o[2][2];
    logic [2:0]  m_bhw[2][2];
    logic        m_wn[2][2], m_dv[2][2], mdv_o[2][2];
    logic [31:0] s_data_o[2], s_addr_o[2], s_rdata[2];
    logic [2:0]  s_bhw_o[2];
    logic        s_wn_o[2], s_dv_o[2], s_rdv[2], grant_o[2], busy_o[2], tmo_o[2];
    logic        s_en[2];
    int          scnt[2];
    logic [31:0] spend[2];

    iss_t iq[2][$];
    rsp_t rq[2][2][$];
    int checks = 0;
    int errors = 0;
    int cyc, hits;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        bus_arbiter #(.RR_EN(d == 0), .TIMEOUT_CYCLES(TO)) dut (
            .i_clk(clk), .i_rst(rst),
            .i_m0_data(m_data[d][0]), .i_m0_address(m_addr[d][0]), .i_m0_bhw(m_bhw[d][0]),
            .i_m0_write_notread(m_wn[d][0]), .i_m0_DV(m_dv[d][0]),
            .i_m1_data(m_data[d][1]), .i_m1_address(m_addr[d][1]), .i_m1_bhw(m_bhw[d][1]),
            .i_m1_write_notread(m_wn[d][1]), .i_m1_DV(m_dv[d][1]),
            .o_m0_data(md_o[d][0]), .o_m0_DV(mdv_o[d][0]),
            .o_m1_data(md_o[d][1]), .o_m1_DV(mdv_o[d][1]),
            .o_slv_data(s_data_o[d]), .o_slv_address(s_addr_o[d]), .o_slv_bhw(s_bhw_o[d]),
            .o_slv_write_notread(s_wn_o[d]), .o_slv_DV(s_dv_o[d]),
            .i_slv_data(s_rdata[d]), .i_slv_DV(s_rdv[d]),
            .o_grant(grant_o[d]), .o_busy(busy_o[d]), .o_timeout(tmo_o[d])
        );
    end

    function automatic logic [31:0] resp_of(input logic [31:0] a);
        return a == 32'h1000 ? 32'hCAFEBABE : a == 32'h3000 ? 32'h11 : a == 32'h3100 ? 32'h22 : ~a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input int d, input int n, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] b, input logic wn);
        m_addr[d][n] = a;
        m_data[d][n] = wd;
        m_bhw[d][n]  = b;
        m_wn[d][n]   = wn;
        m_dv[d][n]   = 1'b1;
        rq[d][n].push_back('{care: !wn, data: resp_of(a)});
    endtask

    task automatic exp_issue(input int d, input int n);
        iq[d].push_back('{addr: m_addr[d][n], data: m_data[d][n], bhw: m_bhw[d][n], wn: m_wn[d][n], m: 1'(n)});
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 2; n++) m_dv[d][n] = 1'b0;
    endtask

    // sel 0/1 waits for o_mN_DV, sel 2 for o_slv_DV
    task automatic wait_sig(input string tag, input int d, input int sel, output int c);
        logic seen;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (sel == 2) seen = s_dv_o[d];
            else seen = mdv_o[d][sel];
        end while (!seen && c < 200);
        if (!seen) check({tag, "_wait"}, 32'd0, 32'd1);
    endtask

    always @(negedge clk)
        for (int d = 0; d < 2; d++) begin
            s_rdv[d] = 1'b0;
            if (s_dv_o[d]) begin
                scnt[d]  = 3;
                spend[d] = resp_of(s_addr_o[d]);
            end else if (scnt[d] != 0) begin
                scnt[d]--;
                if (scnt[d] == 0 && s_en[d]) begin
                    s_rdv[d]   = 1'b1;
                    s_rdata[d] = spend[d];
                end
            end
        end

    always @(negedge clk) begin : mon
        iss_t e;
        rsp_t r;
        if (!rst)
            for (int d = 0; d < 2; d++) begin
                if (s_dv_o[d]) begin
                    if (iq[d].size() == 0) check("slv_dv_unexpected", 32'd1, 32'd0);
                    else begin
                        e = iq[d].pop_front();
                        check("slv_addr", s_addr_o[d], e.addr);
                        check("slv_data", s_data_o[d], e.data);
                        check("slv_bhw", 32'(s_bhw_o[d]), 32'(e.bhw));
                        check("slv_wn", 32'(s_wn_o[d]), 32'(e.wn));
                        check("slv_grant", 32'(grant_o[d]), 32'(e.m));
                    end
                end
                for (int n = 0; n < 2; n++)
                    if (mdv_o[d][n]) begin
                        if (rq[d][n].size() == 0) check("m_dv_unexpected", 32'd1, 32'd0);
                        else begin
                            r = rq[d][n].pop_front();
                            if (r.care) check("m_data", md_o[d][n], r.data);
                        end
                    end
                if (mdv_o[d][0] || mdv_o[d][1])
                    check("dv_exclusive", 32'(mdv_o[d][0] & mdv_o[d][1]), 32'd0);
            end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_en[d]  = 1'b1;
            scnt[d]  = 0;
            for (int n = 0; n < 2; n++) begin
                m_addr[d][n] = '0;
                m_data[d][n] = '0;
                m_bhw[d][n]  = '0;
                m_wn[d][n]   = 1'b0;
                m_dv[d][n]   = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_slv_addr", s_addr_o[d], 32'd0);
            check("rst_slv_data", s_data_o[d], 32'd0);
            check("rst_slv_dv", 32'(s_dv_o[d]), 32'd0);
            check("rst_m0", {md_o[d][0][30:0], mdv_o[d][0]}, 32'd0);
            check("rst_m1", {md_o[d][1][30:0], mdv_o[d][1]}, 32'd0);
            check("rst_ctrl", {29'd0, grant_o[d], busy_o[d], tmo_o[d]}, 32'd0);
        end
        rst = 1'b0;

        // m0 load, latency of request and response
        req(0, 0, 32'h1000, 32'h0, 3'b010, 1'b0);
        exp_issue(0, 0);
        tick();
        check("lat_k_slv_dv", 32'(s_dv_o[0]), 32'd0);
        @(negedge clk);
        check("lat_k1_slv_dv", 32'(s_dv_o[0]), 32'd0);
        check("lat_k1_busy", 32'(busy_o[0]), 32'd1);
        @(negedge clk);
        check("lat_k2_slv_dv", 32'(s_dv_o[0]), 32'd1);
        wait_sig("t1_resp", 0, 0, cyc);
        check("t1_resp_lat", cyc, 32'd4);
        repeat (2) @(negedge clk);
        check("t1_idle", 32'(busy_o[0]), 32'd0);

        // simultaneous pulses: RR serves m1 first, fixed priority serves m0 first
        for (int d = 0; d < 2; d++) begin
            req(d, 1, 32'h3000, 32'h0, 3'b010, 1'b0);
            req(d, 0, 32'h3100, 32'h0, 3'b010, 1'b0);
        end
        exp_issue(0, 1);
        exp_issue(0, 0);
        exp_issue(1, 0);
        exp_issue(1, 1);
        tick();
        wait_sig("t2_m1", 0, 1, cyc);
        wait_sig("t2_bubble", 0, 2, cyc);
        check("t2_bubble_cyc", cyc, 32'd2);
        wait_sig("t2_m0", 0, 0, cyc);
        repeat (3) @(negedge clk);
        check("t2_idle_rr", 32'(busy_o[0]), 32'd0);
        check("t2_idle_fp", 32'(busy_o[1]), 32'd0);

        // fixed priority: m0 re-requests on each response while m1 waits
        req(1, 0, 32'h4000, 32'h0, 3'b010, 1'b0);
        req(1, 1, 32'h4800, 32'h0, 3'b001, 1'b0);
        exp_issue(1, 0);
        exp_issue(1, 1);
        tick();
        for (int i = 1; i < 3; i++) begin
            wait_sig("t3_m0", 1, 0, cyc);
            req(1, 0, 32'h4000 + 32'(i * 4), 32'h0, 3'b010, 1'b0);
            exp_issue(1, 0);
            tick();
        end
        wait_sig("t3_last", 1, 0, cyc);
        repeat (3) @(negedge clk);

        // m1 store
        req(0, 1, 32'h2004, 32'hA5A5A5A5, 3'b000, 1'b1);
        exp_issue(0, 1);
        tick();
        wait_sig("t4_m1", 0, 1, cyc);
        check("t4_grant", 32'(grant_o[0]), 32'd1);
        repeat (2) @(negedge clk);

        // reset while in WAIT; the late slave response must be dropped
        req(0, 0, 32'h5000, 32'h0, 3'b010, 1'b0);
        exp_issue(0, 0);
        tick();
        wait_sig("t5_issue", 0, 2, cyc);
        @(negedge clk);
        rst = 1'b1;
        rq[0][0].delete();
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            hits += int'(mdv_o[0][0]) + int'(mdv_o[0][1]) + int'(s_dv_o[0]);
        end
        check("t5_no_resp", hits, 32'd0);
        check("t5_busy", 32'(busy_o[0]), 32'd0);
        check("t5_grant", 32'(grant_o[0]), 32'd0);
        req(0, 0, 32'h5100, 32'h0, 3'b010, 1'b0);
        exp_issue(0, 0);
        tick();
        wait_sig("t5_fresh", 0, 2, cyc);
        check("t5_fresh_lat", cyc, 32'd2);
        wait_sig("t5_fresh_resp", 0, 0, cyc);
        repeat (2) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        s_en[0] = 1'b0;
        req(0, 0, 32'h6000, 32'h0, 3'b010, 1'b0);
        void'(rq[0][0].pop_back());
        rq[0][0].push_back('{care: 1'b1, data: 32'hDEADBEEF});
        exp_issue(0, 0);
        tick();
        wait_sig("t6_issue", 0, 2, cyc);
        wait_sig("t6_abort", 0, 0, cyc);
        check("t6_abort_lat", cyc, TO);
        @(negedge clk);
        check("t6_timeout", 32'(tmo_o[0]), 32'd1);
        repeat (4) @(negedge clk);
        check("t6_timeout_held", 32'(tmo_o[0]), 32'd1);
        s_en[0] = 1'b1;
`else
        check("timeout_tied_rr", 32'(tmo_o[0]), 32'd0);
        check("timeout_tied_fp", 32'(tmo_o[1]), 32'd0);
`endif
        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("issue_queue_empty", iq[d].size(), 32'd0);
            check("m0_queue_empty", rq[d][0].size(), 32'd0);
            check("m1_queue_empty", rq[d][1].size(), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU memory bus.
- Sits between the CPU core (master 0) and a second bus master such as a debug loader or DMA (master 1), in front of the memory/peripheral bus.
- Captures single-cycle request pulses, serialises them onto the slave bus one transaction at a time, and routes each response back to the master that issued it.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with master 0 winning.
- TIMEOUT_CYCLES, 1024, number of WAIT cycles before abort; used only with ARB_TIMEOUT_EN.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_m0_data / i_m1_data  input  32  write data from master N.
- i_m0_address / i_m1_address  input  32  address from master N.
- i_m0_bhw / i_m1_bhw  input  3  byte/half/word code, passed through unchanged.
- i_m0_write_notread / i_m1_write_notread  input  1  1 = store, 0 = load.
- i_m0_DV / i_m1_DV  input  1  one-cycle request pulse; address, data, bhw and write_notread are valid in the same cycle.
- o_m0_data / o_m1_data  output  32  response data to master N.
- o_m0_DV / o_m1_DV  output  1  one-cycle response pulse.
- o_slv_data, o_slv_address  output  32  forwarded request.
- o_slv_bhw  output  3  forwarded bhw.
- o_slv_write_notread  output  1  forwarded direction.
- o_slv_DV  output  1  one-cycle request pulse to the slave.
- i_slv_data  input  32  slave response data.
- i_slv_DV  input  1  one-cycle slave response pulse.
- o_grant  output  1  master owning the current or last transaction.
- o_busy  output  1  high in ISSUE or WAIT.
- o_timeout  output  1  sticky abort flag.

Behaviour:
- Reset: state IDLE; pending flags cleared; all o_*_DV = 0; all data and address outputs = 0; o_grant = 0; o_busy = 0; o_timeout = 0; round-robin pointer set so that master 0 wins first.
- Capture:
  - Each master has a pending flag and a request register (address, data, bhw, write_notread).
  - i_mN_DV = 1 with pending N = 0: the request is registered and pending N is set at that edge.
  - i_mN_DV = 1 with pending N = 1 (protocol violation): the request is ignored and the stored request is not overwritten.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - No pending request: stay in IDLE.
  - Only one pending: grant that master.
  - Both pending, RR_EN = 1: grant the master not granted last.
  - Both pending, RR_EN = 0: grant master 0.
  - On grant: latch o_grant, drive the o_slv_* fields from that master's request register, go to ISSUE.
- ISSUE: o_slv_DV = 1 for exactly this cycle, then go to WAIT. o_slv_* fields hold their values until the next grant.
- WAIT:
  - On i_slv_DV = 1: o_mG_data = i_slv_data, o_mG_DV = 1 for one cycle, clear pending G, update the round-robin pointer, go to IDLE.
  - A pulse to master G is sent for stores as well; its data is don't-care.
- Latency:
  - A request sampled at edge k produces o_slv_DV high in the cycle after edge k+2, provided the arbiter was IDLE with nothing pending.
  - i_slv_DV sampled at edge m produces o_mG_DV high in the cycle after edge m.
- Back-to-back: a competing request pending during WAIT is granted on the first IDLE cycle, giving a 1-cycle bubble.
- Simultaneous events:
  - Both masters pulse in the same cycle: both are captured and arbitration follows RR_EN.
  - A request from master G in the same cycle as its own response: master G is still pending, so the request is ignored.
- Stray responses: i_slv_DV outside WAIT is ignored.
- Reset mid-transaction: everything returns to reset values, the in-flight transaction is dropped, and no response is delivered.
- o_m0_DV and o_m1_DV are never high in the same cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without i_slv_DV: o_mG_DV = 1 with o_mG_data = 32'hDEADBEEF, o_timeout set (sticky until reset), pending G cleared, go to IDLE.
- Undefined: no counter; WAIT waits indefinitely; o_timeout is tied to 0.

Test Plan:
- Reset, then m0 load to 0x1000, bhw = 3'b010; slave answers 0xCAFEBABE 3 cycles after o_slv_DV -> o_slv_address = 0x1000, o_slv_write_notread = 0; o_m0_DV pulses once with 0xCAFEBABE; o_m1_DV stays 0.
- m0 and m1 pulse in the same cycle, RR_EN = 1, last grant = 0 -> m1 is issued first, then m0; each receives its own data (0x11 and 0x22), with a 1-cycle bubble between issues.
- RR_EN = 0; m1 pending while m0 issues 3 consecutive requests, each re-issued on its response -> m1 is served only in an IDLE cycle where m0 is not pending; no DV overlap.
- m1 store of 0xA5A5A5A5 to 0x2004, bhw = 3'b000 -> o_slv_data = 0xA5A5A5A5 and o_slv_write_notread = 1; o_m1_DV pulses on the slave acknowledge.
- i_rst asserted during WAIT, then i_slv_DV arrives 2 cycles later -> no o_mN_DV, state IDLE, pending flags 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and the slave never answering -> after 8 WAIT cycles o_m0_DV = 1, o_m0_data = 0xDEADBEEF, o_timeout = 1 and held.
